// File: rtl/blockram_arbiter2.sv
// ----------------------------------------------------------------------------
// blockram_arbiter2
//
// Two-master round-robin arbiter in front of the single port of the on-chip
// block RAM. Requests are forwarded to the memory port in the same cycle,
// tagged with the owning master's ID. Returned read beats are routed back to
// their master by tag. Each master may have at most one read burst
// outstanding.
//
// Optional feature macro: BLOCKRAM_ARB_STATS_EN
//   defined   -> grant_cnt_a / grant_cnt_b count accepted requests per master
//                (16-bit, wrapping, cleared by reset)
//   undefined -> grant_cnt_a / grant_cnt_b are tied to zero, no counter flops
//
// Ports
//   clock                 single clock, all state on the rising edge
//   rst                   synchronous reset, active low
//   a_* / b_*             master request ports (address, read/write strobes,
//                         write data and byte mask in; waitrequest, read data
//                         and read-data-valid out)
//   s_*                   memory-side port (granted request out, tag on s_id;
//                         s_waitrequest, returned beat and its tag in)
//   grant_cnt_a/b         accepted-request counters (optional feature)
// ----------------------------------------------------------------------------
module blockram_arbiter2 #(
    parameter int unsigned BURST_BITS = 2,
    parameter logic [1:0]  ID_A       = 2'd1,
    parameter logic [1:0]  ID_B       = 2'd2
) (
    input  logic        clock,
    input  logic        rst,

    input  logic [29:0] a_address,
    input  logic        a_read,
    input  logic        a_write,
    input  logic [31:0] a_writedata,
    input  logic [3:0]  a_writedatamask,
    output logic        a_waitrequest,
    output logic [31:0] a_readdata,
    output logic        a_readdatavalid,

    input  logic [29:0] b_address,
    input  logic        b_read,
    input  logic        b_write,
    input  logic [31:0] b_writedata,
    input  logic [3:0]  b_writedatamask,
    output logic        b_waitrequest,
    output logic [31:0] b_readdata,
    output logic        b_readdatavalid,

    input  logic        s_waitrequest,
    output logic [1:0]  s_id,
    output logic [29:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_writedatamask,
    input  logic [31:0] s_readdata,
    input  logic [1:0]  s_readdataid,

    output logic [15:0] grant_cnt_a,
    output logic [15:0] grant_cnt_b
);

    localparam logic [BURST_BITS:0] LAST_BEAT = (BURST_BITS+1)'((1 << BURST_BITS) - 1);

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_grant_e;

    last_grant_e             last_q, last_d;
    logic                    pend_a_q, pend_a_d;
    logic                    pend_b_q, pend_b_d;
    logic [BURST_BITS:0]     beat_a_q, beat_a_d;
    logic [BURST_BITS:0]     beat_b_q, beat_b_d;

    logic                    elig_a, elig_b;
    logic                    grant_a, grant_b;

    // ------------------------------------------------------------------
    // Eligibility and grant. Reset holds both masters off so every
    // waitrequest stays high while rst is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        elig_a  = rst && (a_read || a_write) && !s_waitrequest && !(a_read && pend_a_q);
        elig_b  = rst && (b_read || b_write) && !s_waitrequest && !(b_read && pend_b_q);
        // On a tie the master that did not win last time goes first.
        grant_a = elig_a && (!elig_b || (last_q == LAST_B));
        grant_b = elig_b && (!elig_a || (last_q == LAST_A));
    end

    // ------------------------------------------------------------------
    // Request path: granted master muxed straight onto the memory port.
    // ------------------------------------------------------------------
    always_comb begin
        s_id            = '0;
        s_address       = '0;
        s_read          = 1'b0;
        s_write         = 1'b0;
        s_writedata     = '0;
        s_writedatamask = '0;
        if (grant_a) begin
            s_id            = ID_A;
            s_address       = a_address;
            s_read          = a_read;
            s_write         = a_write;
            s_writedata     = a_writedata;
            s_writedatamask = a_writedatamask;
        end else if (grant_b) begin
            s_id            = ID_B;
            s_address       = b_address;
            s_read          = b_read;
            s_write         = b_write;
            s_writedata     = b_writedata;
            s_writedatamask = b_writedatamask;
        end
    end

    assign a_waitrequest = !grant_a;
    assign b_waitrequest = !grant_b;

    // ------------------------------------------------------------------
    // Read return path. Beats only count for a master with a pending
    // burst; anything else (ID 0, unknown ID, no pending read) is dropped.
    // ------------------------------------------------------------------
    assign a_readdata      = s_readdata;
    assign b_readdata      = s_readdata;
    assign a_readdatavalid = pend_a_q && (s_readdataid == ID_A);
    assign b_readdatavalid = pend_b_q && (s_readdataid == ID_B);

    // ------------------------------------------------------------------
    // Next-state: last grant and per-master burst tracking.
    // An accepted read and a returning beat cannot coincide for the same
    // master, since acceptance needs pend=0 and a counted beat needs pend=1.
    // ------------------------------------------------------------------
    always_comb begin
        last_d   = last_q;
        pend_a_d = pend_a_q;
        pend_b_d = pend_b_q;
        beat_a_d = beat_a_q;
        beat_b_d = beat_b_q;

        if (grant_a) begin
            last_d = LAST_A;
        end else if (grant_b) begin
            last_d = LAST_B;
        end

        if (grant_a && a_read) begin
            pend_a_d = 1'b1;
            beat_a_d = '0;
        end else if (a_readdatavalid) begin
            beat_a_d = beat_a_q + 1'b1;
            if (beat_a_q == LAST_BEAT) begin
                pend_a_d = 1'b0;
            end
        end

        if (grant_b && b_read) begin
            pend_b_d = 1'b1;
            beat_b_d = '0;
        end else if (b_readdatavalid) begin
            beat_b_d = beat_b_q + 1'b1;
            if (beat_b_q == LAST_BEAT) begin
                pend_b_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            last_q   <= LAST_B;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            beat_a_q <= '0;
            beat_b_q <= '0;
        end else begin
            last_q   <= last_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            beat_a_q <= beat_a_d;
            beat_b_q <= beat_b_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional grant statistics.
    // ------------------------------------------------------------------
`ifdef BLOCKRAM_ARB_STATS_EN
    logic [15:0] cnt_a_q, cnt_a_d;
    logic [15:0] cnt_b_q, cnt_b_d;

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (grant_a) begin
            cnt_a_d = cnt_a_q + 16'd1;
        end
        if (grant_b) begin
            cnt_b_d = cnt_b_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign grant_cnt_a = cnt_a_q;
    assign grant_cnt_b = cnt_b_q;
`else
    assign grant_cnt_a = '0;
    assign grant_cnt_b = '0;
`endif

endmodule

// File: tb/tb_blockram_arbiter2.sv
module tb_blockram_arbiter2;

    logic        clock;
    logic        rst;
    logic [29:0] a_address, b_address, s_address;
    logic        a_read, a_write, b_read, b_write, s_read, s_write;
    logic [31:0] a_writedata, b_writedata, s_writedata;
    logic [3:0]  a_writedatamask, b_writedatamask, s_writedatamask;
    logic        a_waitrequest, b_waitrequest, s_waitrequest;
    logic [31:0] a_readdata, b_readdata, s_readdata;
    logic        a_readdatavalid, b_readdatavalid;
    logic [1:0]  s_id, s_readdataid;
    logic [15:0] grant_cnt_a, grant_cnt_b;

    int total = 0;
    int bad   = 0;

    blockram_arbiter2 #(.BURST_BITS(2), .ID_A(2'd1), .ID_B(2'd2)) dut (
        .clock(clock), .rst(rst),
        .a_address(a_address), .a_read(a_read), .a_write(a_write),
        .a_writedata(a_writedata), .a_writedatamask(a_writedatamask),
        .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
        .a_readdatavalid(a_readdatavalid),
        .b_address(b_address), .b_read(b_read), .b_write(b_write),
        .b_writedata(b_writedata), .b_writedatamask(b_writedatamask),
        .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
        .b_readdatavalid(b_readdatavalid),
        .s_waitrequest(s_waitrequest), .s_id(s_id), .s_address(s_address),
        .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
        .s_writedatamask(s_writedatamask), .s_readdata(s_readdata),
        .s_readdataid(s_readdataid),
        .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Inputs change 1 time unit after a rising edge; outputs are sampled
    // 3 units later, well clear of either clock edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        a_address = '0; a_read = 1'b0; a_write = 1'b0; a_writedata = '0; a_writedatamask = '0;
        b_address = '0; b_read = 1'b0; b_write = 1'b0; b_writedata = '0; b_writedatamask = '0;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdataid = '0;

        // Reset: requests present but everything held off.
        tick();
        a_read = 1'b1; a_address = 30'h100;
        settle();
        chk("rst_a_wait", a_waitrequest, 1);
        chk("rst_b_wait", b_waitrequest, 1);
        chk("rst_s_id", s_id, 0);
        chk("rst_s_read", s_read, 0);
        chk("rst_cnt_a", grant_cnt_a, 0);

        // 1. Lone A read, forwarded in the same cycle.
        tick();
        rst = 1'b1;
        settle();
        chk("t1_s_read", s_read, 1);
        chk("t1_s_id", s_id, 1);
        chk("t1_s_addr", s_address, 32'h100);
        chk("t1_a_wait", a_waitrequest, 0);
        chk("t1_b_wait", b_waitrequest, 1);
        tick();
        a_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_readdataid = 2'd1; s_readdata = 32'hA000_0000 + i;
            settle();
            chk("t1_a_valid", a_readdatavalid, 1);
            chk("t1_a_data", a_readdata, 32'hA000_0000 + i);
            chk("t1_b_valid", b_readdatavalid, 0);
            tick();
        end
        // Burst complete: a fifth beat tagged A is dropped.
        s_readdataid = 2'd1;
        settle();
        chk("t1_extra_beat", a_readdatavalid, 0);
        tick();
        // 4. Tag of a master with nothing pending, and an unknown tag.
        s_readdataid = 2'd2;
        settle();
        chk("t4_b_nopend", b_readdatavalid, 0);
        chk("t4_a_nopend", a_readdatavalid, 0);
        tick();
        s_readdataid = 2'd0;

        // 2. Simultaneous reads right after reset: A wins the first tie.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        a_read = 1'b1; a_address = 30'h111;
        b_read = 1'b1; b_address = 30'h222;
        settle();
        chk("t2_tie_sid", s_id, 1);
        chk("t2_tie_a_wait", a_waitrequest, 0);
        chk("t2_tie_b_wait", b_waitrequest, 1);
        tick();
        a_read = 1'b0;
        s_waitrequest = 1'b1;
        settle();
        chk("t2_busy_b_wait", b_waitrequest, 1);
        chk("t2_busy_sid", s_id, 0);
        chk("t2_busy_addr", s_address, 0);
        tick();
        s_waitrequest = 1'b0;
        settle();
        chk("t2_b_sid", s_id, 2);
        chk("t2_b_addr", s_address, 32'h222);
        chk("t2_b_wait", b_waitrequest, 0);
        tick();
        b_read = 1'b0;
        // Both reads pending; writes still allowed. Last grant was B, so A wins.
        a_write = 1'b1; a_writedata = 32'h1111_1111; a_writedatamask = 4'h3;
        b_write = 1'b1; b_writedata = 32'h2222_2222; b_writedatamask = 4'hC;
        settle();
        chk("t2_tie2_sid", s_id, 1);
        chk("t2_tie2_write", s_write, 1);
        chk("t2_tie2_wdata", s_writedata, 32'h1111_1111);
        tick();
        settle();
        chk("t2_tie3_sid", s_id, 2);
        chk("t2_tie3_mask", s_writedatamask, 4'hC);
        tick();
        a_write = 1'b0; b_write = 1'b0;
        // 4. Unknown tag 3 while both are pending.
        s_readdataid = 2'd3;
        settle();
        chk("t4_id3_a", a_readdatavalid, 0);
        chk("t4_id3_b", b_readdatavalid, 0);
        tick();
        s_readdataid = 2'd0;
        rst = 1'b0;
        tick();
        rst = 1'b1;

        // 3. Second A read blocked until the cycle after A's last beat.
        a_read = 1'b1; a_address = 30'h200;
        settle();
        chk("t3_first_acc", a_waitrequest, 0);
        tick();
        a_address = 30'h204;
        b_write = 1'b1; b_address = 30'h333;
        b_writedata = 32'hDEADBEEF; b_writedatamask = 4'hF;
        for (int i = 0; i < 4; i++) begin
            s_readdataid = 2'd1;
            settle();
            chk("t3_a_blocked", a_waitrequest, 1);
            chk("t3_a_valid", a_readdatavalid, 1);
            if (i == 0) begin
                chk("t3_b_wr_sid", s_id, 2);
                chk("t3_b_wr_data", s_writedata, 32'hDEADBEEF);
                chk("t3_b_wr_mask", s_writedatamask, 4'hF);
                chk("t3_b_wait", b_waitrequest, 0);
            end
            tick();
            b_write = 1'b0;
        end
        s_readdataid = 2'd0;
        settle();
        chk("t3_a_reacc", a_waitrequest, 0);
        chk("t3_a_reacc_addr", s_address, 32'h204);
        chk("t3_a_reacc_read", s_read, 1);
        tick();
        a_read = 1'b0;

        // 5. Reset after two beats abandons the burst.
        s_readdataid = 2'd1;
        settle();
        chk("t5_beat1", a_readdatavalid, 1);
        tick();
        settle();
        chk("t5_beat2", a_readdatavalid, 1);
        tick();
        s_readdataid = 2'd0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        s_readdataid = 2'd1;
        settle();
        chk("t5_drop3", a_readdatavalid, 0);
        tick();
        settle();
        chk("t5_drop4", a_readdatavalid, 0);
        tick();
        s_readdataid = 2'd0;
        a_read = 1'b1; a_address = 30'h400;
        settle();
        chk("t5_new_read", a_waitrequest, 0);
        chk("t5_new_sid", s_id, 1);
        tick();
        a_read = 1'b0;

        // 6. Grant statistics: 3 A writes, 2 B reads.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        a_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t6_a_wr_acc", a_waitrequest, 0);
            tick();
        end
        a_write = 1'b0;
        b_read = 1'b1;
        tick();
        b_read = 1'b0;
        s_readdataid = 2'd2;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t6_b_valid", b_readdatavalid, 1);
            tick();
        end
        s_readdataid = 2'd0;
        b_read = 1'b1;
        settle();
        chk("t6_b_rd2_acc", b_waitrequest, 0);
        tick();
        b_read = 1'b0;
        settle();
`ifdef BLOCKRAM_ARB_STATS_EN
        chk("t6_cnt_a", grant_cnt_a, 3);
        chk("t6_cnt_b", grant_cnt_b, 2);
`else
        chk("t6_cnt_a", grant_cnt_a, 0);
        chk("t6_cnt_b", grant_cnt_b, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
